// File: rtl/sha_message_schedule.sv
// SHA-256 message schedule: latches one 512-bit block, streams W0..W63 with K0..K63.
// Latency: first word valid 1 cycle after block acceptance; 1-cycle DONE gap per block.
// Backpressure: out_ready low freezes Wt/Kt/t and the window; block_ready only in IDLE.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   block_valid/block_ready   512-bit message block handshake (M0 = block[511:480])
//   out_valid/out_ready       per-round word handshake carrying Wt, Kt, t, last
//   done                      one-cycle pulse after round 63 is accepted
module sha_message_schedule #(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         block_valid,
  output logic         block_ready,
  input  logic [511:0] block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  Wt,
  output logic [31:0]  Kt,
  output logic [5:0]   t,
  output logic         last,
  output logic         done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [5:0] LAST_T = 6'(NUM_ROUNDS - 1);

  logic [1:0]  state_q, state_d;
  logic [5:0]  t_q, t_d;
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [31:0] w_next;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] k_rom(input logic [5:0] idx);
    logic [31:0] k;
    case (idx)
      6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  // Window slot 0 is the word being emitted; slot 15 receives the word 16 rounds ahead.
  assign w_next = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    for (int i = 0; i < 16; i++) w_d[i] = w_q[i];
    case (state_q)
      S_IDLE: begin
        if (block_valid) begin
          for (int i = 0; i < 16; i++) w_d[i] = block[511 - 32*i -: 32];
          t_d     = 6'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (out_ready) begin
          for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
          w_d[15] = w_next;
          // Exit is decided on the final index, so t never wraps inside a block.
          if (t_q == LAST_T) begin
            t_d     = 6'd0;
            state_d = S_DONE;
          end else begin
            t_d = t_q + 6'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      t_q     <= 6'd0;
      for (int i = 0; i < 16; i++) w_q[i] <= 32'h0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      for (int i = 0; i < 16; i++) w_q[i] <= w_d[i];
    end
  end

  assign block_ready = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_RUN);
  // Word outputs are forced to zero outside RUN so reset/idle present clean zeros.
  assign Wt          = out_valid ? w_q[0] : 32'h0;
  assign Kt          = out_valid ? k_rom(t_q) : 32'h0;
  assign t           = t_q;
  assign last        = out_valid && (t_q == LAST_T);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_sha_message_schedule.sv
module tb_sha_message_schedule;

  logic         clk;
  logic         reset_n;
  logic         block_valid;
  logic         block_ready;
  logic [511:0] block;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  Wt;
  logic [31:0]  Kt;
  logic [5:0]   t;
  logic         last;
  logic         done;

  sha_message_schedule dut (
    .clk(clk), .reset_n(reset_n),
    .block_valid(block_valid), .block_ready(block_ready), .block(block),
    .out_valid(out_valid), .out_ready(out_ready),
    .Wt(Wt), .Kt(Kt), .t(t), .last(last), .done(done)
  );

  typedef struct {
    logic [5:0]  t;
    logic [31:0] w;
    logic [31:0] k;
    logic        last;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_done_cyc = -1000;
  bit done_exp = 0;
  bit abc_mode = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: one 5-cycle stall at t=20
  int stall_gen = 0;

  logic [31:0] KTAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference: full 64-entry schedule array built directly from the recurrence.
  task automatic push_expected(input logic [511:0] b);
    logic [31:0] w [64];
    exp_t e;
    for (int i = 0; i < 16; i++) w[i] = b[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 64; i++) begin
      e.t = 6'(i); e.w = w[i]; e.k = KTAB[i]; e.last = (i == 63);
      q.push_back(e);
    end
  endtask

  // out_ready driver
  initial begin
    int stall_cnt = 0;
    int stall_seen = 0;
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (stall_cnt > 0) begin
            out_ready = 1'b0;
            stall_cnt--;
          end else if (stall_gen != stall_seen && out_valid && t == 6'd20) begin
            out_ready  = 1'b0;
            stall_cnt  = 4;
            stall_seen = stall_gen;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every presented word against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        done_exp = 0;
      end else begin
        chk("done", {63'b0, done}, {63'b0, done_exp});
        if (done) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
        done_exp = 0;
        if (out_valid) begin
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: got t=%0d Wt=%h expected no output", t, Wt);
          end else begin
            e = q[0];
            chk("word", {t, Wt, Kt, last}, {e.t, e.w, e.k, e.last});
            if (abc_mode && out_ready) begin
              case (t)
                6'd0:  chk("abc_t0",  {Wt, Kt}, {32'h61626380, 32'h428a2f98});
                6'd15: chk("abc_t15", {32'h0, Wt}, {32'h0, 32'h00000018});
                6'd16: chk("abc_t16", {32'h0, Wt}, {32'h0, 32'h61626380});
                6'd17: chk("abc_t17", {32'h0, Wt}, {32'h0, 32'h000f0000});
                6'd62: chk("abc_t62", {Wt, Kt}, {32'heeaba2cc, 32'hbef9a3f7});
                6'd63: chk("abc_t63", {31'b0, last, Kt}, {31'b0, 1'b1, 32'hc67178f2});
                default: ;
              endcase
            end
            if (out_ready) begin
              void'(q.pop_front());
              if (e.last) done_exp = 1;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [511:0] b, input bit keep, output int acc);
    bit ok = 0;
    acc = -1;
    @(posedge clk);
    #1;
    block = b;
    block_valid = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (block_ready) begin
        acc = cyc;
        push_expected(b);
        ok = 1;
        break;
      end
    end
    chk("accept_timeout", {63'b0, ok}, 64'd1);
    @(posedge clk);
    #1;
    // When held, the source keeps valid high with different data during RUN.
    if (keep) block = ~b;
    else block_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge clk);
      if (q.size() == 0 && block_ready && !done) begin
        ok = 1;
        break;
      end
    end
    chk("idle_timeout", {63'b0, ok}, 64'd1);
  endtask

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  initial begin
    logic [511:0] abc;
    logic [511:0] ba;
    logic [511:0] bb;
    int acc;
    bit ok;
    abc = {32'h61626380, 448'h0, 32'h00000018};
    reset_n = 1'b1;
    block_valid = 1'b0;
    block = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_block_ready", {63'b0, block_ready}, 64'd1);
    chk("rst_t_w_k", {22'b0, t, Wt, Kt}, 64'd0);
    chk("rst_last_done", {62'b0, last, done}, 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // abc, always ready: also check done timing relative to acceptance
    rdy_mode = 0;
    abc_mode = 1;
    send(abc, 0, acc);
    wait_idle();
    chk("abc_done_latency", 64'(last_done_cyc - acc), 64'd65);

    // abc with a 5-cycle stall at t=20
    rdy_mode = 2;
    stall_gen++;
    send(abc, 0, acc);
    wait_idle();
    abc_mode = 0;

    // random blocks, random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      send(rand_block(), 0, acc);
      wait_idle();
    end

    // back-to-back: valid held high through the first block's run
    ba = rand_block();
    bb = rand_block();
    send(ba, 1, acc);
    send(bb, 0, acc);
    chk("b2b_gap", 64'(acc), 64'(last_done_cyc + 1));
    wait_idle();

    // reset in the middle of a block, then a fresh block
    rdy_mode = 0;
    send(rand_block(), 0, acc);
    ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (out_valid && t == 6'd30) begin
        ok = 1;
        break;
      end
    end
    chk("t30_timeout", {63'b0, ok}, 64'd1);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("midrst_block_ready", {63'b0, block_ready}, 64'd1);
    chk("midrst_t_w_k", {22'b0, t, Wt, Kt}, 64'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send(rand_block(), 0, acc);
    wait_idle();
    repeat (3) @(negedge clk);

    chk("queue_empty", 64'(q.size()), 64'd0);
    chk("done_count", 64'(done_cnt), 64'd15);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha_message_schedule.md
Name: sha_message_schedule

Overview:
- Sequential producer of the per-round (Wt, Kt) word pair consumed by the combinational SHA-256 round.
- Accepts one 512-bit message block and streams the 64 expanded schedule words with their round constants, one per accepted transfer.
- Sits between the block source and the round/state datapath; it drives the Kt and Wt inputs of sha_round.

Parameters:
- NUM_ROUNDS, 64, number of schedule words emitted per block; fixed by SHA-256, not intended to be changed.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- block_valid  input  1  message block offered
- block_ready  output  1  block accepted this cycle when block_valid && block_ready
- block  input  512  message words; M0 = block[511:480], M15 = block[31:0]
- out_valid  output  1  Wt/Kt/t are valid
- out_ready  input  1  consumer takes the word this cycle when out_valid && out_ready
- Wt  output  32  schedule word for round t
- Kt  output  32  SHA-256 round constant for round t
- t  output  6  round index 0..63
- last  output  1  high with out_valid when t == 63
- done  output  1  one-cycle pulse the cycle after round 63 is accepted

Behaviour:
- Reset (async assert, sync release): state IDLE, block_ready=1, out_valid=0, Wt=0, Kt=0, t=0, last=0, done=0, window registers cleared.
- States:
  - IDLE: block_ready=1, out_valid=0. On block_valid, latch M0..M15 into a 16-word window W[0..15], set t=0, go to RUN. Outputs become valid the next cycle, so latency is 1 cycle from block acceptance to the first out_valid.
  - RUN: block_ready=0, out_valid=1, Wt=W[0], Kt=K[t] from an internal 64-entry constant ROM, indexed combinationally or registered with t.
    - On out_ready: shift the window down one word, W[15] <= Wnext, t <= t+1.
    - Wnext = σ1(W[14]) + W[9] + σ0(W[1]) + W[0], mod 2^32.
    - σ0(x) = ROTR7 ^ ROTR18 ^ SHR3.
    - σ1(x) = ROTR17 ^ ROTR19 ^ SHR10.
    - Words 0..15 therefore equal M0..M15, and words 16..63 follow the standard recurrence.
  - Stall: while out_ready=0, Wt, Kt, t and the window hold exactly. No word is skipped or duplicated.
  - End of block: when t==63 and out_ready=1, go to DONE.
  - DONE: single cycle. done=1, out_valid=0, block_ready=0. Next state IDLE.
- Back-to-back blocks: the earliest acceptance of the next block is the cycle after DONE. The gap is 1 idle cycle of out_valid plus the 1-cycle load latency.
- block_valid during RUN/DONE is ignored and not latched. The source must hold it until block_ready.
- Counter t is 6 bits and never wraps within a block. The transition out of RUN is decided on t==63, not on overflow.
- Reset mid-RUN: outputs return to reset values immediately. The partial block is discarded, with no done pulse.
- Arithmetic: all additions are 32-bit modulo, carries discarded.
- Must be synthesizable (no initial blocks for the ROM contents other than a case statement).

Test Plan:
- Reset: assert reset_n=0 mid-stream → out_valid=0, block_ready=1, t=0, Wt=0, Kt=0 asynchronously, before the next clk edge.
- "abc" block (block = 61626380 followed by 14 zero words, then 00000018), out_ready held 1:
  - t=0: Wt=61626380, Kt=428a2f98.
  - t=15: Wt=00000018.
  - t=16: Wt=61626380.
  - t=17: Wt=000f0000.
  - t=62: Wt=eeaba2cc, Kt=bef9a3f7.
  - t=63: Kt=c67178f2, last=1.
  - done pulses exactly once, 65 cycles after block acceptance.
- Stall: same block, drop out_ready for 5 cycles at t=20 → Wt/Kt/t frozen for those cycles. The resulting 64-word sequence is identical to the no-stall run.
- Random out_ready (50%) over 10 random blocks: compare every (t, Wt, Kt) against a reference model. Exactly 64 transfers per block and one done per block.
- Back-to-back: block_valid held high with two different blocks → second acceptance occurs the cycle after done. Each stream starts at t=0, and block_valid during RUN has no effect.
- Reset at t=30 then a new block → stream restarts at t=0 with the new block's M0, and no done is emitted for the aborted block.
